// File: rtl/wb_spram_bridge.sv
// Wishbone B4 pipelined slave in front of a single-port 32-bit RAM with one cycle of read latency.
// Every request is acked two cycles after it is accepted. Define WB_SPRAM_BRIDGE_RANGE_CHECK_EN to return wb_err for addresses at or above size.
module wb_spram_bridge #(
  parameter int unsigned size       = 'h80,
  parameter int unsigned addr_width = $clog2(size) - 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_cyc,
  input  logic                  wb_stb,
  input  logic                  wb_we,
  input  logic [3:0]            wb_sel,
  input  logic [31:0]           wb_adr,
  input  logic [31:0]           wb_dat_i,
  output logic                  wb_stall,
  output logic                  wb_ack,
  output logic                  wb_err,
  output logic [31:0]           wb_dat_o,
  output logic [addr_width-1:0] ram_addr,
  output logic                  ram_ce,
  output logic [3:0]            ram_we,
  output logic [31:0]           ram_d,
  input  logic [31:0]           ram_q
);

  logic acc;
  logic req_err;
  logic unused_adr;

  logic s1_valid;
  logic s1_read;
  logic s1_err;
  logic s2_valid;
  logic s2_err;

  assign acc = wb_cyc & wb_stb;

`ifdef WB_SPRAM_BRIDGE_RANGE_CHECK_EN
  assign req_err    = (wb_adr >= size);
  assign unused_adr = ^wb_adr[1:0];
`else
  // Upper address bits are dropped, so out-of-range addresses wrap modulo size.
  assign req_err    = 1'b0;
  assign unused_adr = ^{wb_adr[31:addr_width+2], wb_adr[1:0]};
`endif

  // The RAM is driven straight from the bus in the accept cycle.
  assign ram_ce   = rst_n & acc & ~req_err;
  assign ram_addr = wb_adr[addr_width+1:2];
  assign ram_we   = (acc & wb_we) ? wb_sel : 4'b0000;
  assign ram_d    = wb_dat_i;

  assign wb_stall = 1'b0;

  // S1 lines up with the RAM output; S2 presents the response to the bus.
  // Dropping wb_cyc flushes both stages, so in-flight responses never appear.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every stage samples the pre-edge values.
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_read  <= 1'b0;
      s1_err   <= 1'b0;
      s2_valid <= 1'b0;
      s2_err   <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      s1_valid <= acc;
      s1_read  <= ~wb_we;
      s1_err   <= req_err;
      s2_valid <= wb_cyc & s1_valid;
      s2_err   <= s1_err;
      if (wb_cyc && s1_valid && s1_read && !s1_err) begin
        wb_dat_o <= ram_q;
      end
    end
  end

  assign wb_ack = s2_valid & ~s2_err;

`ifdef WB_SPRAM_BRIDGE_RANGE_CHECK_EN
  assign wb_err = s2_valid & s2_err;
`else
  assign wb_err = 1'b0;
`endif

endmodule

// File: tb/tb_wb_spram_bridge.sv
// Self-checking bench for wb_spram_bridge: a behavioural RAM, directed vector table, corner-case sequences
// and a randomized run, all compared against a queue-based response model.
module tb_wb_spram_bridge;

  localparam int unsigned SIZE  = 'h80;
  localparam int          AW    = 5;
  localparam int          WORDS = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wb_cyc = 1'b0;
  logic          wb_stb = 1'b0;
  logic          wb_we = 1'b0;
  logic [3:0]    wb_sel = 4'h0;
  logic [31:0]   wb_adr = '0;
  logic [31:0]   wb_dat_i = '0;
  logic          wb_stall;
  logic          wb_ack;
  logic          wb_err;
  logic [31:0]   wb_dat_o;
  logic [AW-1:0] ram_addr;
  logic          ram_ce;
  logic [3:0]    ram_we;
  logic [31:0]   ram_d;
  logic [31:0]   ram_q = '0;

  wb_spram_bridge #(.size(SIZE), .addr_width(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_cyc   (wb_cyc),
    .wb_stb   (wb_stb),
    .wb_we    (wb_we),
    .wb_sel   (wb_sel),
    .wb_adr   (wb_adr),
    .wb_dat_i (wb_dat_i),
    .wb_stall (wb_stall),
    .wb_ack   (wb_ack),
    .wb_err   (wb_err),
    .wb_dat_o (wb_dat_o),
    .ram_addr (ram_addr),
    .ram_ce   (ram_ce),
    .ram_we   (ram_we),
    .ram_d    (ram_d),
    .ram_q    (ram_q)
  );

  always #5 clk = ~clk;

  // Attached single-port RAM: byte-enabled write, registered read-first output.
  logic [31:0] ram_mem [WORDS] = '{default: '0};
  always @(posedge clk) begin
    if (ram_ce) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_d[8*b +: 8];
      end
      ram_q <= ram_mem[ram_addr];
    end
  end

  // Reference model: memory image updated at accept time plus a queue of responses due at a given edge.
  typedef struct {
    int          due;
    bit          rd;
    bit          err;
    logic [31:0] data;
  } resp_t;

  resp_t       pend[$];
  logic [31:0] ref_mem [WORDS];
  logic [31:0] exp_dat;
  bit          exp_ack;
  bit          exp_err;
  int          edge_cnt = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit addr_err(input logic [31:0] adr);
`ifdef WB_SPRAM_BRIDGE_RANGE_CHECK_EN
    return adr >= SIZE;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int word_of(input logic [31:0] adr);
    return int'(adr[AW+1:2]);
  endfunction

  task automatic bus_cycle(input logic rst, input logic cyc, input logic stb, input logic we,
                           input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
    resp_t r;
    int    idx;
    rst_n = rst; wb_cyc = cyc; wb_stb = stb; wb_we = we;
    wb_sel = sel; wb_adr = adr; wb_dat_i = dat;
    #1;
    idx = word_of(adr);
    check("ram_ce", ram_ce, rst & cyc & stb & ~addr_err(adr));
    check("ram_addr", ram_addr, idx);
    check("ram_we", ram_we, (cyc & stb & we) ? sel : 4'h0);
    check("ram_d", ram_d, dat);
    check("wb_stall", wb_stall, 0);
    @(posedge clk);
    edge_cnt++;
    if (!rst) begin
      pend.delete();
      exp_dat = '0;
    end else if (!cyc) begin
      pend.delete();
    end else if (stb) begin
      r.due  = edge_cnt + 1;
      r.rd   = !we;
      r.err  = addr_err(adr);
      r.data = ref_mem[idx];
      if (we && !r.err) begin
        for (int b = 0; b < 4; b++) begin
          if (sel[b]) ref_mem[idx][8*b +: 8] = dat[8*b +: 8];
        end
      end
      pend.push_back(r);
    end
    exp_ack = 1'b0;
    exp_err = 1'b0;
    if (pend.size() > 0 && pend[0].due == edge_cnt) begin
      r = pend.pop_front();
      exp_ack = !r.err;
      exp_err = r.err;
      if (r.rd && !r.err) exp_dat = r.data;
    end
    @(negedge clk);
    check("wb_ack", wb_ack, exp_ack);
    check("wb_err", wb_err, exp_err);
    check("wb_dat_o", wb_dat_o, exp_dat);
  endtask

  task automatic wr(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    bus_cycle(1'b1, 1'b1, 1'b1, 1'b1, sel, adr, dat);
  endtask

  task automatic rd(input logic [31:0] adr);
    bus_cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'hF, adr, 32'h0);
  endtask

  task automatic idle();
    bus_cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic drop();
    bus_cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  typedef struct {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        exp_ack;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs[13];

  initial begin
    for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
    exp_dat = '0;

    // Each row's expectations are what the bus shows after that row's edge (ack of the row before it).
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 4'hF, 32'h14, 32'h11223344, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b1, 32'h0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0,        1'b1, 32'h0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 4'h2, 32'h14, 32'hAABBCCDD, 1'b1, 32'hDEADBEEF};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 4'hF, 32'h14, 32'h0,        1'b1, 32'hDEADBEEF};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h0,  32'h0,        1'b1, 32'h1122CC44};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h0,  32'h0,        1'b0, 32'h1122CC44};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 4'h0, 32'h10, 32'h0,        1'b0, 32'h1122CC44};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0,        1'b1, 32'h1122CC44};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h0,  32'h0,        1'b1, 32'hDEADBEEF};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 4'h1, 32'h14, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h0,  32'h0,        1'b1, 32'h1122CC44};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h0,  32'h0,        1'b0, 32'h1122CC44};

    // Reset held with an active request on the bus.
    for (int i = 0; i < 3; i++) bus_cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
    check("reset ram_ce", ram_ce, 0);
    check("reset wb_ack", wb_ack, 0);
    check("reset wb_err", wb_err, 0);
    check("reset wb_dat_o", wb_dat_o, 0);
    idle();

    // Write/read, byte lanes, zero-sel write, partial-sel read.
    for (int i = 0; i < 13; i++) begin
      bus_cycle(1'b1, vecs[i].cyc, vecs[i].stb, vecs[i].we, vecs[i].sel, vecs[i].adr, vecs[i].dat);
      check($sformatf("vec%0d ack", i), wb_ack, vecs[i].exp_ack);
      check($sformatf("vec%0d dat", i), wb_dat_o, vecs[i].exp_dat);
    end

    // Streaming: eight back-to-back reads give eight consecutive acks in order.
    for (int i = 0; i < 8; i++) wr(i * 4, 4'hF, i);
    for (int i = 0; i < 8; i++) begin
      rd(i * 4);
      if (i > 0) begin
        check($sformatf("stream ack %0d", i - 1), wb_ack, 1);
        check($sformatf("stream dat %0d", i - 1), wb_dat_o, i - 1);
      end
    end
    idle();
    check("stream ack 7", wb_ack, 1);
    check("stream dat 7", wb_dat_o, 7);
    idle();

    // Abort: two reads in flight, then wb_cyc drops.
    rd(32'h0);
    rd(32'h4);
    for (int i = 0; i < 3; i++) begin
      drop();
      check($sformatf("abort no ack %0d", i), wb_ack | wb_err, 0);
    end
    wr(32'h20, 4'hF, 32'h0BADF00D);
    rd(32'h20);
    idle();
    idle();
    check("post-abort dat", wb_dat_o, 32'h0BADF00D);

    // Reset in the middle of a transfer.
    wr(32'h08, 4'hF, 32'h12345678);
    rd(32'h08);
    rd(32'h08);
    bus_cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h08, 32'h0);
    check("midreset ack", wb_ack, 0);
    check("midreset dat", wb_dat_o, 0);
    idle();

    // Out-of-range write: err with the check enabled, alias onto word 0 otherwise.
    wr(32'h0, 4'hF, 32'h5A5A5A5A);
    wr(32'h80, 4'hF, 32'hCAFEF00D);
    idle();
`ifdef WB_SPRAM_BRIDGE_RANGE_CHECK_EN
    check("range err", wb_err, 1);
    check("range ack", wb_ack, 0);
    idle();
    check("range word0", ram_mem[0], 32'h5A5A5A5A);
`else
    check("alias ack", wb_ack, 1);
    check("alias err", wb_err, 0);
    idle();
    check("alias word0", ram_mem[0], 32'hCAFEF00D);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic        c;
      logic        s;
      logic [31:0] a;
      c = ($urandom_range(0, 15) != 0);
      s = ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 'hFF));
      bus_cycle(1'b1, c, s, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom());
    end
    idle();
    idle();
    idle();
    for (int i = 0; i < WORDS; i++) check($sformatf("mem word %0d", i), ram_mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
